// File: rtl/apb_bridge_pkg.sv
// Shared definitions for the AHB-to-APB bridge: FSM states, AHB codes, APB slave map.
// Decode helpers are pure combinational functions used by the address pipe.
package apb_bridge_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_RENABLE,
      ST_WWAIT,
      ST_WRITE,
      ST_WENABLE,
      ST_WRITEP,
      ST_WENABLEP
   } state_t;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [1:0] HRESP_OKAY = 2'b00;

   // Three 64 MB APB slaves packed contiguously from 0x8000_0000.
   localparam logic [31:0] SLV0_BASE = 32'h8000_0000;
   localparam logic [31:0] SLV1_BASE = 32'h8400_0000;
   localparam logic [31:0] SLV2_BASE = 32'h8800_0000;
   localparam logic [31:0] SLV_END   = 32'h8C00_0000;

   typedef struct packed {
      logic [2:0]  psel;
      logic        penable;
      logic        pwrite;
      logic [31:0] paddr;
      logic [31:0] pwdata;
      logic        hreadyout;
   } apb_out_t;

   localparam apb_out_t APB_RESET = '{
      psel: 3'b000, penable: 1'b0, pwrite: 1'b0,
      paddr: 32'h0, pwdata: 32'h0, hreadyout: 1'b1
   };

   function automatic logic [2:0] decode_psel(input logic [31:0] addr);
      logic [2:0] sel;
      sel = 3'b000;
      if (addr >= SLV0_BASE && addr < SLV1_BASE)
         sel = 3'b001;
      else if (addr >= SLV1_BASE && addr < SLV2_BASE)
         sel = 3'b010;
      else if (addr >= SLV2_BASE && addr < SLV_END)
         sel = 3'b100;
      return sel;
   endfunction

   function automatic logic addr_in_range(input logic [31:0] addr);
      return (addr >= SLV0_BASE) && (addr < SLV_END);
   endfunction

endpackage

// File: rtl/ahb_slave_pipe.sv
// AHB address/data pipeline and transfer qualification; registers load whenever Hreadyin is high.
// Valid and current-address decode are combinational; no backpressure of its own.
module ahb_slave_pipe
   import apb_bridge_pkg::*;
(
   input  logic        i_hclk,
   input  logic        i_hresetn,
   input  logic        i_hreadyin,
   input  logic        i_hwrite,
   input  logic [1:0]  i_htrans,
   input  logic [31:0] i_haddr,
   input  logic [31:0] i_hwdata,
   output logic        o_valid,
   output logic [2:0]  o_psel_cur,
   output logic [31:0] o_haddr_r1,
   output logic [31:0] o_haddr_r2,
   output logic [2:0]  o_psel_r1,
   output logic [2:0]  o_psel_r2,
   output logic [31:0] o_hwdata_r,
   output logic        o_hwrite_r
);

   logic [31:0] r_haddr1;
   logic [31:0] r_haddr2;
   logic [31:0] r_hwdata;
   logic        r_hwrite;
   logic        w_active_trans;

   always_ff @(posedge i_hclk or negedge i_hresetn) begin
      if (!i_hresetn) begin
         r_haddr1 <= 32'h0;
         r_haddr2 <= 32'h0;
         r_hwdata <= 32'h0;
         r_hwrite <= 1'b0;
      end else if (i_hreadyin) begin
         r_haddr1 <= i_haddr;
         r_haddr2 <= r_haddr1;
         r_hwdata <= i_hwdata;
         r_hwrite <= i_hwrite;
      end
   end

   // BUSY and IDLE never start an APB access.
   assign w_active_trans = (i_htrans == HTRANS_NONSEQ) || (i_htrans == HTRANS_SEQ);
   assign o_valid        = i_hreadyin && w_active_trans && addr_in_range(i_haddr);

   assign o_psel_cur = decode_psel(i_haddr);
   assign o_psel_r1  = decode_psel(r_haddr1);
   assign o_psel_r2  = decode_psel(r_haddr2);
   assign o_haddr_r1 = r_haddr1;
   assign o_haddr_r2 = r_haddr2;
   assign o_hwdata_r = r_hwdata;
   assign o_hwrite_r = r_hwrite;

endmodule

// File: rtl/apb_bridge_controller.sv
// AHB-to-APB bridge: reads take SETUP+ENABLE (2 cycles), writes wait one cycle for data.
// Hreadyout drops during APB SETUP and during pipelined-write stalls.
module apb_bridge_controller
   import apb_bridge_pkg::*;
(
   input  logic        Hclk,
   input  logic        Hresetn,
   input  logic        Hwrite,
   input  logic        Hreadyin,
   input  logic [1:0]  Htrans,
   input  logic [31:0] Haddr,
   input  logic [31:0] Hwdata,
   input  logic [31:0] Prdata,
   output logic [2:0]  Psel,
   output logic        Penable,
   output logic        Pwrite,
   output logic [31:0] Paddr,
   output logic [31:0] Pwdata,
   output logic        Hreadyout,
   output logic [31:0] Hrdata,
   output logic [1:0]  Hresp
);

   logic        w_valid;
   logic [2:0]  w_psel_cur;
   logic [31:0] w_haddr_r1;
   logic [31:0] w_haddr_r2;
   logic [2:0]  w_psel_r1;
   logic [2:0]  w_psel_r2;
   logic [31:0] w_hwdata_r;
   logic        w_hwrite_r;

   state_t      r_state;
   state_t      w_next_state;
   apb_out_t    r_apb;
   apb_out_t    w_apb_next;

   ahb_slave_pipe u_pipe (
      .i_hclk     (Hclk),
      .i_hresetn  (Hresetn),
      .i_hreadyin (Hreadyin),
      .i_hwrite   (Hwrite),
      .i_htrans   (Htrans),
      .i_haddr    (Haddr),
      .i_hwdata   (Hwdata),
      .o_valid    (w_valid),
      .o_psel_cur (w_psel_cur),
      .o_haddr_r1 (w_haddr_r1),
      .o_haddr_r2 (w_haddr_r2),
      .o_psel_r1  (w_psel_r1),
      .o_psel_r2  (w_psel_r2),
      .o_hwdata_r (w_hwdata_r),
      .o_hwrite_r (w_hwrite_r)
   );

   always_ff @(posedge Hclk or negedge Hresetn) begin
      if (!Hresetn) begin
         r_state <= ST_IDLE;
         r_apb   <= APB_RESET;
      end else begin
         r_state <= w_next_state;
         r_apb   <= w_apb_next;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_apb_next   = r_apb;

      unique case (r_state)
         ST_IDLE:
            if (w_valid && Hwrite)       w_next_state = ST_WWAIT;
            else if (w_valid)            w_next_state = ST_READ;
            else                         w_next_state = ST_IDLE;
         ST_WWAIT:
            w_next_state = w_valid ? ST_WRITEP : ST_WRITE;
         ST_READ:
            w_next_state = ST_RENABLE;
         ST_WRITEP:
            w_next_state = ST_WENABLEP;
         ST_RENABLE, ST_WENABLE:
            if (w_valid && !Hwrite)      w_next_state = ST_READ;
            else if (w_valid)            w_next_state = ST_WWAIT;
            else                         w_next_state = ST_IDLE;
         ST_WRITE:
            w_next_state = w_valid ? ST_WENABLEP : ST_WENABLE;
         ST_WENABLEP:
            if (!w_hwrite_r)             w_next_state = ST_READ;
            else if (w_valid)            w_next_state = ST_WRITEP;
            else                         w_next_state = ST_WRITE;
         default:
            w_next_state = ST_IDLE;
      endcase

      // Outputs are loaded with the values belonging to the state being entered.
      unique case (w_next_state)
         ST_IDLE, ST_WWAIT: begin
            w_apb_next.psel      = 3'b000;
            w_apb_next.penable   = 1'b0;
            w_apb_next.hreadyout = 1'b1;
         end
         ST_READ: begin
            w_apb_next.paddr     = Haddr;
            w_apb_next.psel      = w_psel_cur;
            w_apb_next.pwrite    = 1'b0;
            w_apb_next.penable   = 1'b0;
            w_apb_next.hreadyout = 1'b0;
         end
         ST_WRITE, ST_WRITEP: begin
            // A write issued out of WENABLEP is one pipeline stage further back.
            if (r_state == ST_WENABLEP) begin
               w_apb_next.paddr  = w_haddr_r2;
               w_apb_next.pwdata = w_hwdata_r;
               w_apb_next.psel   = w_psel_r2;
            end else begin
               w_apb_next.paddr  = w_haddr_r1;
               w_apb_next.pwdata = Hwdata;
               w_apb_next.psel   = w_psel_r1;
            end
            w_apb_next.pwrite    = 1'b1;
            w_apb_next.penable   = 1'b0;
            w_apb_next.hreadyout = 1'b0;
         end
         ST_RENABLE, ST_WENABLE: begin
            w_apb_next.penable   = 1'b1;
            w_apb_next.hreadyout = 1'b1;
         end
         ST_WENABLEP: begin
            w_apb_next.penable   = 1'b1;
            w_apb_next.hreadyout = 1'b0;
         end
         default: begin
            w_apb_next = APB_RESET;
         end
      endcase
   end

   assign Psel      = r_apb.psel;
   assign Penable   = r_apb.penable;
   assign Pwrite    = r_apb.pwrite;
   assign Paddr     = r_apb.paddr;
   assign Pwdata    = r_apb.pwdata;
   assign Hreadyout = r_apb.hreadyout;
   assign Hrdata    = Prdata;
   assign Hresp     = HRESP_OKAY;

endmodule

// File: tb/tb_apb_bridge_controller.sv
// Vector table bench for the AHB-to-APB bridge with an expected-output queue per cycle,
// plus hand-written reset-during-transfer sequence.
module tb_apb_bridge_controller;

   logic        Hclk = 1'b0;
   logic        Hresetn = 1'b0;
   logic        Hwrite = 1'b0;
   logic        Hreadyin = 1'b1;
   logic [1:0]  Htrans = 2'b00;
   logic [31:0] Haddr = 32'h0;
   logic [31:0] Hwdata = 32'h0;
   logic [31:0] Prdata = 32'h0;
   logic [2:0]  Psel;
   logic        Penable;
   logic        Pwrite;
   logic [31:0] Paddr;
   logic [31:0] Pwdata;
   logic        Hreadyout;
   logic [31:0] Hrdata;
   logic [1:0]  Hresp;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        rdy;
      logic [1:0]  tr;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [2:0]  psel;
      logic        pen;
      logic        pwr;
      logic [31:0] paddr;
      logic [31:0] pwdata;
      logic        hrdy;
   } vec_t;

   typedef struct {
      logic [2:0]  psel;
      logic        pen;
      logic        pwr;
      logic [31:0] paddr;
      logic [31:0] pwdata;
      logic        hrdy;
      logic [31:0] prdata;
   } exp_t;

   vec_t vt[$];
   exp_t exp_q[$];

   apb_bridge_controller dut (
      .Hclk      (Hclk),
      .Hresetn   (Hresetn),
      .Hwrite    (Hwrite),
      .Hreadyin  (Hreadyin),
      .Htrans    (Htrans),
      .Haddr     (Haddr),
      .Hwdata    (Hwdata),
      .Prdata    (Prdata),
      .Psel      (Psel),
      .Penable   (Penable),
      .Pwrite    (Pwrite),
      .Paddr     (Paddr),
      .Pwdata    (Pwdata),
      .Hreadyout (Hreadyout),
      .Hrdata    (Hrdata),
      .Hresp     (Hresp)
   );

   always #5 Hclk = ~Hclk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic rdy, input logic [1:0] tr, input logic wr,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [2:0] psel, input logic pen, input logic pwr,
                      input logic [31:0] paddr, input logic [31:0] pwdata, input logic hrdy);
      vec_t v;
      v.rdy = rdy;  v.tr = tr;  v.wr = wr;  v.addr = addr;  v.wdata = wdata;
      v.psel = psel;  v.pen = pen;  v.pwr = pwr;  v.paddr = paddr;  v.pwdata = pwdata;
      v.hrdy = hrdy;
      vt.push_back(v);
   endtask

   task automatic drive(input logic rdy, input logic [1:0] tr, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wdata);
      Hreadyin = rdy;  Htrans = tr;  Hwrite = wr;  Haddr = addr;  Hwdata = wdata;
   endtask

   task automatic check_out(input string tag, input exp_t e);
      check({tag, ".psel"},   {29'h0, Psel},      {29'h0, e.psel});
      check({tag, ".pen"},    {31'h0, Penable},   {31'h0, e.pen});
      check({tag, ".pwrite"}, {31'h0, Pwrite},    {31'h0, e.pwr});
      check({tag, ".paddr"},  Paddr,              e.paddr);
      check({tag, ".pwdata"}, Pwdata,             e.pwdata);
      check({tag, ".hready"}, {31'h0, Hreadyout}, {31'h0, e.hrdy});
      check({tag, ".hrdata"}, Hrdata,             e.prdata);
      check({tag, ".hresp"},  {30'h0, Hresp},     32'h0);
   endtask

   initial begin
      exp_t e;
      exp_t got;

      // Expected outputs after the clock edge that consumes each row's inputs.
      // single read
      add(1, 2'b10, 0, 32'h8000_0010, 0, 3'b001, 0, 0, 32'h8000_0010, 32'h0, 0);
      add(1, 2'b00, 0, 32'h0,         0, 3'b001, 1, 0, 32'h8000_0010, 32'h0, 1);
      add(1, 2'b00, 0, 32'h0,         0, 3'b000, 0, 0, 32'h8000_0010, 32'h0, 1);
      // single write: WWAIT, WRITE, WENABLE, IDLE
      add(1, 2'b10, 1, 32'h8400_0004, 0,            3'b000, 0, 0, 32'h8000_0010, 32'h0,        1);
      add(1, 2'b00, 0, 32'h0,         32'hDEADBEEF, 3'b010, 0, 1, 32'h8400_0004, 32'hDEADBEEF, 0);
      add(1, 2'b00, 0, 32'h0,         0,            3'b010, 1, 1, 32'h8400_0004, 32'hDEADBEEF, 1);
      add(1, 2'b00, 0, 32'h0,         0,            3'b000, 0, 1, 32'h8400_0004, 32'hDEADBEEF, 1);
      // back-to-back writes: WWAIT, WRITEP, WENABLEP, WRITE, WENABLE, IDLE
      add(1, 2'b10, 1, 32'h8800_0000, 0,            3'b000, 0, 1, 32'h8400_0004, 32'hDEADBEEF, 1);
      add(1, 2'b11, 1, 32'h8800_0004, 32'h1111_1111, 3'b100, 0, 1, 32'h8800_0000, 32'h1111_1111, 0);
      add(1, 2'b00, 1, 32'h8800_0004, 32'h2222_2222, 3'b100, 1, 1, 32'h8800_0000, 32'h1111_1111, 0);
      add(1, 2'b00, 0, 32'h0,         0,             3'b100, 0, 1, 32'h8800_0004, 32'h2222_2222, 0);
      add(1, 2'b00, 0, 32'h0,         0,             3'b100, 1, 1, 32'h8800_0004, 32'h2222_2222, 1);
      add(1, 2'b00, 0, 32'h0,         0,             3'b000, 0, 1, 32'h8800_0004, 32'h2222_2222, 1);
      // transfers that must not start an access
      add(1, 2'b10, 0, 32'h9000_0000, 0, 3'b000, 0, 1, 32'h8800_0004, 32'h2222_2222, 1);
      add(1, 2'b01, 0, 32'h8000_0000, 0, 3'b000, 0, 1, 32'h8800_0004, 32'h2222_2222, 1);
      add(1, 2'b10, 1, 32'h8C00_0000, 0, 3'b000, 0, 1, 32'h8800_0004, 32'h2222_2222, 1);
      add(1, 2'b11, 0, 32'h7FFF_FFFC, 0, 3'b000, 0, 1, 32'h8800_0004, 32'h2222_2222, 1);
      add(0, 2'b10, 0, 32'h8000_0000, 0, 3'b000, 0, 1, 32'h8800_0004, 32'h2222_2222, 1);
      // range edges: top of slave 2, then RENABLE straight into a read of slave 1 base
      add(1, 2'b10, 0, 32'h8BFF_FFFC, 0, 3'b100, 0, 0, 32'h8BFF_FFFC, 32'h2222_2222, 0);
      add(1, 2'b00, 0, 32'h0,         0, 3'b100, 1, 0, 32'h8BFF_FFFC, 32'h2222_2222, 1);
      add(1, 2'b10, 0, 32'h8400_0000, 0, 3'b010, 0, 0, 32'h8400_0000, 32'h2222_2222, 0);
      add(1, 2'b00, 0, 32'h0,         0, 3'b010, 1, 0, 32'h8400_0000, 32'h2222_2222, 1);
      add(1, 2'b10, 0, 32'h83FF_FFFC, 0, 3'b001, 0, 0, 32'h83FF_FFFC, 32'h2222_2222, 0);
      add(1, 2'b00, 0, 32'h0,         0, 3'b001, 1, 0, 32'h83FF_FFFC, 32'h2222_2222, 1);
      add(1, 2'b00, 0, 32'h0,         0, 3'b000, 0, 0, 32'h83FF_FFFC, 32'h2222_2222, 1);

      #12;
      e = '{psel: 3'b000, pen: 1'b0, pwr: 1'b0, paddr: 32'h0, pwdata: 32'h0,
            hrdy: 1'b1, prdata: 32'h0};
      check_out("reset", e);
      @(negedge Hclk);
      Hresetn = 1'b1;

      foreach (vt[i]) begin
         drive(vt[i].rdy, vt[i].tr, vt[i].wr, vt[i].addr, vt[i].wdata);
         Prdata = $urandom;
         e = '{psel: vt[i].psel, pen: vt[i].pen, pwr: vt[i].pwr, paddr: vt[i].paddr,
               pwdata: vt[i].pwdata, hrdy: vt[i].hrdy, prdata: Prdata};
         exp_q.push_back(e);
         @(posedge Hclk);
         #1;
         got = exp_q.pop_front();
         check_out($sformatf("v%0d", i), got);
      end

      // Reset asserted while the bridge sits in WENABLEP.
      drive(1, 2'b10, 1, 32'h8800_0000, 32'h0);
      @(posedge Hclk); #1;
      drive(1, 2'b11, 1, 32'h8800_0004, 32'h3333_3333);
      @(posedge Hclk); #1;
      drive(1, 2'b00, 1, 32'h8800_0004, 32'h4444_4444);
      @(posedge Hclk); #1;
      check("wenp.pen",    {31'h0, Penable},   32'h1);
      check("wenp.hready", {31'h0, Hreadyout}, 32'h0);
      #2;
      Hresetn = 1'b0;
      #1;
      e = '{psel: 3'b000, pen: 1'b0, pwr: 1'b0, paddr: 32'h0, pwdata: 32'h0,
            hrdy: 1'b1, prdata: Prdata};
      check_out("rst_mid", e);
      drive(1, 2'b00, 1, 32'h0, 32'h0);
      @(negedge Hclk);
      Hresetn = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge Hclk); #1;
         check_out($sformatf("post_rst%0d", k), e);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
